pc_npc_unit: RTL and testbench

Fetch-side consumer of the ID-stage control word: holds the fetch PC and the IF/ID PC register, and turns `npc_op`, the D-stage instruction fields and the forwarded register operands into the next fetch address every cycle. It sits between the ID-stage control decoder and the instruction memory. It implements MIPS branch-delay-slot semantics, so there is no flush. It also counts taken redirects for performance monitoring.

---
 rtl/pc_npc_unit_pkg.sv | 18 +
 rtl/pc_npc_unit_branch_cmp.sv | 26 ++
 rtl/pc_npc_unit.sv | 100 ++++++++++
 tb/tb_pc_npc_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_npc_unit_pkg.sv
// Shared next-PC opcodes and reset address for the
// fetch-side PC unit and the ID-stage decoder.
package pc_npc_unit_pkg;

  localparam logic [3:0] NPC_SEQ  = 4'd0;
  localparam logic [3:0] NPC_BEQ  = 4'd1;
  localparam logic [3:0] NPC_J    = 4'd2;
  localparam logic [3:0] NPC_JR   = 4'd3;
  localparam logic [3:0] NPC_JALR = 4'd4;
  localparam logic [3:0] NPC_BNE  = 4'd5;
  localparam logic [3:0] NPC_BGTZ = 4'd6;
  localparam logic [3:0] NPC_BLEZ = 4'd7;
  localparam logic [3:0] NPC_BGEZ = 4'd8;
  localparam logic [3:0] NPC_BLTZ = 4'd9;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

endpackage

// File: rtl/pc_npc_unit_branch_cmp.sv
// Branch condition evaluation for the ID-stage branch.
// Only conditional codes can raise cond_o.
module branch_cmp
  import pc_npc_unit_pkg::*;
(
  input  logic [3:0]  npc_op,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  output logic        cond_o
);

  // Evaluate the compare selected by the next-PC code
  always_comb begin
    cond_o = 1'b0;
    case (npc_op)
      NPC_BEQ:  cond_o = (rd1 == rd2);
      NPC_BNE:  cond_o = (rd1 != rd2);
      NPC_BGTZ: cond_o = ($signed(rd1) >  32'sd0);
      NPC_BLEZ: cond_o = ($signed(rd1) <= 32'sd0);
      NPC_BGEZ: cond_o = ($signed(rd1) >= 32'sd0);
      NPC_BLTZ: cond_o = ($signed(rd1) <  32'sd0);
      default:  cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_npc_unit.sv
// Fetch PC, IF/ID PC and next-PC selection with
// delay-slot semantics and a taken-redirect counter.
module pc_npc_unit
  import pc_npc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [3:0]       npc_op,
  input  logic [31:0]      instr_D,
  input  logic [31:0]      rd1,
  input  logic [31:0]      rd2,
  output logic [31:0]      pc_F,
  output logic [31:0]      pc_D,
  output logic [31:0]      pc8_D,
  output logic             taken_D,
  output logic             adel_F,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [31:0]      pc_f_q, pc_f_d;
  logic [31:0]      pc_d_q, pc_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      br_tgt, j_tgt, tgt, npc;
  logic             cond;
  logic             unused_opc;

  branch_cmp u_cmp (
    .npc_op (npc_op),
    .rd1    (rd1),
    .rd2    (rd2),
    .cond_o (cond)
  );

  assign unused_opc = ^instr_D[31:26];

  assign br_tgt = pc_d_q + 32'd4
                + {{14{instr_D[15]}}, instr_D[15:0], 2'b00};
  assign j_tgt  = {pc_d_q[31:28], instr_D[25:0], 2'b00};

  // Redirect decision and target for the ID instruction
  always_comb begin
    taken_D = 1'b0;
    tgt     = br_tgt;
    case (npc_op)
      NPC_J: begin
        taken_D = 1'b1;
        tgt     = j_tgt;
      end
      NPC_JR, NPC_JALR: begin
        taken_D = 1'b1;
        tgt     = rd1;
      end
      NPC_BEQ, NPC_BNE, NPC_BGTZ,
      NPC_BLEZ, NPC_BGEZ, NPC_BLTZ: begin
        taken_D = cond;
      end
      default: begin
        taken_D = 1'b0;
      end
    endcase
  end

  assign npc = taken_D ? tgt : pc_f_q + 32'd4;

  // Next state: a stall holds all three registers
  always_comb begin
    pc_f_d = pc_f_q;
    pc_d_d = pc_d_q;
    cnt_d  = cnt_q;
    if (!stall) begin
      pc_f_d = npc;
      pc_d_d = pc_f_q;
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, taken_D};
    end
  end

  // PC and counter registers, async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q <= RESET_PC;
      pc_d_q <= 32'd0;
      cnt_q  <= '0;
    end else begin
      pc_f_q <= pc_f_d;
      pc_d_q <= pc_d_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pc_F      = pc_f_q;
  assign pc_D      = pc_d_q;
  assign pc8_D     = pc_d_q + 32'd8;
  assign adel_F    = (pc_f_q[1:0] != 2'b00);
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_pc_npc_unit.sv
// Self-checking bench for pc_npc_unit: directed table,
// stall/reset sequences, counter wrap, random vs model.
module tb_pc_npc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [3:0]  npc_op;
  logic [31:0] instr_D;
  logic [31:0] rd1;
  logic [31:0] rd2;

  logic [31:0] pc_F, pc_D, pc8_D;
  logic        taken_D, adel_F;
  logic [31:0] taken_cnt;

  logic [31:0] pc_F4, pc_D4, pc8_D4;
  logic        taken_D4, adel_F4;
  logic [3:0]  taken_cnt4;

  int n_err;
  int n_chk;

  logic [31:0] m_pcf, m_pcd, m_cnt, m_npc;
  logic        m_tk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic        tk;
    logic [31:0] pcf;
    logic [31:0] pcd;
    logic [31:0] cnt;
    logic        adel;
  } vec_t;

  vec_t tbl [17];

  pc_npc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .npc_op    (npc_op),
    .instr_D   (instr_D),
    .rd1       (rd1),
    .rd2       (rd2),
    .pc_F      (pc_F),
    .pc_D      (pc_D),
    .pc8_D     (pc8_D),
    .taken_D   (taken_D),
    .adel_F    (adel_F),
    .taken_cnt (taken_cnt)
  );

  pc_npc_unit #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .npc_op    (npc_op),
    .instr_D   (instr_D),
    .rd1       (rd1),
    .rd2       (rd2),
    .pc_F      (pc_F4),
    .pc_D      (pc_D4),
    .pc8_D     (pc8_D4),
    .taken_D   (taken_D4),
    .adel_F    (adel_F4),
    .taken_cnt (taken_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic ref_taken(input logic [3:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    int sa;
    sa = int'(a);
    case (op)
      4'd1: return a == b;
      4'd2, 4'd3, 4'd4: return 1'b1;
      4'd5: return a != b;
      4'd6: return sa > 0;
      4'd7: return sa <= 0;
      4'd8: return sa >= 0;
      4'd9: return sa < 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [3:0] op,
                                             input logic [31:0] pcd,
                                             input logic [31:0] ins,
                                             input logic [31:0] a);
    int off;
    logic [31:0] t;
    off = int'($signed(ins[15:0])) * 4;
    t = pcd + 32'd4 + 32'(off);
    if (op == 4'd2) t = {pcd[31:28], 28'h0} + ins[25:0] * 32'd4;
    if (op == 4'd3 || op == 4'd4) t = a;
    return t;
  endfunction

  // Drive inputs and precompute the model's next state
  task automatic set_in(input logic s, input logic [3:0] op,
                        input logic [31:0] ins,
                        input logic [31:0] a,
                        input logic [31:0] b);
    stall   = s;
    npc_op  = op;
    instr_D = ins;
    rd1     = a;
    rd2     = b;
    m_tk  = ref_taken(op, a, b);
    m_npc = m_tk ? ref_target(op, m_pcd, ins, a) : m_pcf + 32'd4;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!stall) begin
      m_pcd = m_pcf;
      m_pcf = m_npc;
      m_cnt = m_cnt + 32'(m_tk);
    end
  endtask

  task automatic model_reset();
    m_pcf = 32'h0000_3000;
    m_pcd = 32'd0;
    m_cnt = 32'd0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " pc_F"}, pc_F, m_pcf);
    chk({tag, " pc_D"}, pc_D, m_pcd);
    chk({tag, " pc8_D"}, pc8_D, m_pcd + 32'd8);
    chk({tag, " adel_F"}, 32'(adel_F), 32'(m_pcf[1:0] != 2'b00));
    chk({tag, " cnt"}, taken_cnt, m_cnt);
    chk({tag, " cnt4"}, 32'(taken_cnt4), 32'(m_cnt[3:0]));
    chk({tag, " pc_F4"}, pc_F4, m_pcf);
    chk({tag, " pc_D4"}, pc_D4, m_pcd);
    chk({tag, " pc8_D4"}, pc8_D4, m_pcd + 32'd8);
    chk({tag, " adel_F4"}, 32'(adel_F4), 32'(adel_F));
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    reset = 1'b1;
    stall = 1'b0;
    npc_op = 4'd0;
    instr_D = 32'd0;
    rd1 = 32'd0;
    rd2 = 32'd0;
    model_reset();

    tbl[0]  = '{4'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                32'h3004, 32'h3000, 32'd0, 1'b0};
    tbl[1]  = '{4'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                32'h3008, 32'h3004, 32'd0, 1'b0};
    tbl[2]  = '{4'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                32'h300C, 32'h3008, 32'd0, 1'b0};
    tbl[3]  = '{4'd1, 32'h1000_FFFE, 32'd5, 32'd5, 1'b1,
                32'h3004, 32'h300C, 32'd1, 1'b0};
    tbl[4]  = '{4'd6, 32'h0, 32'h8000_0000, 32'h0, 1'b0,
                32'h3008, 32'h3004, 32'd1, 1'b0};
    tbl[5]  = '{4'd9, 32'h0000_0010, 32'h8000_0000, 32'h0, 1'b1,
                32'h3048, 32'h3008, 32'd2, 1'b0};
    tbl[6]  = '{4'd3, 32'h0, 32'h0000_3102, 32'h0, 1'b1,
                32'h3102, 32'h3048, 32'd3, 1'b1};
    tbl[7]  = '{4'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                32'h3106, 32'h3102, 32'd3, 1'b1};
    tbl[8]  = '{4'd3, 32'h0, 32'h3000_0010, 32'h0, 1'b1,
                32'h3000_0010, 32'h3106, 32'd4, 1'b0};
    tbl[9]  = '{4'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                32'h3000_0014, 32'h3000_0010, 32'd4, 1'b0};
    tbl[10] = '{4'd2, 32'h0800_0400, 32'h0, 32'h0, 1'b1,
                32'h3000_1000, 32'h3000_0014, 32'd5, 1'b0};
    tbl[11] = '{4'd5, 32'h0, 32'd7, 32'd7, 1'b0,
                32'h3000_1004, 32'h3000_1000, 32'd5, 1'b0};
    tbl[12] = '{4'd7, 32'h0000_FFFF, 32'd0, 32'h0, 1'b1,
                32'h3000_1000, 32'h3000_1004, 32'd6, 1'b0};
    tbl[13] = '{4'd8, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0,
                32'h3000_1004, 32'h3000_1000, 32'd6, 1'b0};
    tbl[14] = '{4'd12, 32'h0, 32'h0, 32'h0, 1'b0,
                32'h3000_1008, 32'h3000_1004, 32'd6, 1'b0};
    tbl[15] = '{4'd3, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1,
                32'hFFFF_FFFC, 32'h3000_1008, 32'd7, 1'b0};
    tbl[16] = '{4'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                32'h0000_0000, 32'hFFFF_FFFC, 32'd7, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst pc_F", pc_F, 32'h3000);
    chk("rst pc_D", pc_D, 32'h0);
    chk("rst pc8_D", pc8_D, 32'h8);
    chk("rst adel", 32'(adel_F), 32'h0);
    chk("rst cnt", taken_cnt, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_in(1'b0, tbl[i].op, tbl[i].ins, tbl[i].a, tbl[i].b);
      chk($sformatf("v%0d taken", i), 32'(taken_D), 32'(tbl[i].tk));
      tick();
      chk($sformatf("v%0d pc_F", i), pc_F, tbl[i].pcf);
      chk($sformatf("v%0d pc_D", i), pc_D, tbl[i].pcd);
      chk($sformatf("v%0d pc8", i), pc8_D, tbl[i].pcd + 32'd8);
      chk($sformatf("v%0d cnt", i), taken_cnt, tbl[i].cnt);
      chk($sformatf("v%0d adel", i), 32'(adel_F), 32'(tbl[i].adel));
    end

    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 4'd4, 32'h0, 32'h100 * 32'(i + 1), 32'h0);
      chk("stall taken", 32'(taken_D), 32'h1);
      tick();
      chk("stall pc_F", pc_F, 32'h0);
      chk("stall pc_D", pc_D, 32'hFFFF_FFFC);
      chk("stall cnt", taken_cnt, 32'd7);
    end
    set_in(1'b0, 4'd4, 32'h0, 32'h0000_4000, 32'h0);
    tick();
    chk("release pc_F", pc_F, 32'h0000_4000);
    chk("release pc_D", pc_D, 32'h0);
    chk("release cnt", taken_cnt, 32'd8);

    set_in(1'b1, 4'd3, 32'h0, 32'h0000_5000, 32'h0);
    tick();
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst pc_F", pc_F, 32'h3000);
    chk("arst pc_D", pc_D, 32'h0);
    chk("arst pc8_D", pc8_D, 32'h8);
    chk("arst adel", 32'(adel_F), 32'h0);
    chk("arst cnt", taken_cnt, 32'h0);
    chk("arst cnt4", 32'(taken_cnt4), 32'h0);
    tick();
    reset = 1'b0;
    set_in(1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("post-rst pc_F", pc_F, 32'h3004);
    chk_all("post-rst");

    for (int i = 0; i < 15; i++) begin
      set_in(1'b0, 4'd2, 32'h0800_0000 | 32'(i * 4), 32'h0, 32'h0);
      tick();
    end
    chk("cnt4 full", 32'(taken_cnt4), 32'hF);
    set_in(1'b0, 4'd2, 32'h0800_0100, 32'h0, 32'h0);
    tick();
    chk("cnt4 wrap", 32'(taken_cnt4), 32'h0);
    chk("cnt32 no wrap", taken_cnt, 32'd16);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      logic s;
      a = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
      s = ($urandom_range(0, 3) == 0);
      set_in(s, 4'($urandom_range(0, 15)), 32'($urandom), a, b);
      chk("rnd taken", 32'(taken_D), 32'(m_tk));
      chk("rnd taken4", 32'(taken_D4), 32'(m_tk));
      tick();
      chk_all("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
